uart_param: RTL and testbench

//   Full-duplex UART, parametrised successor of the fixed 8N1 buart pair.

---
 rtl/uart_param.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_param.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with a first-word-fall-through
// RX FIFO.
//
// Parameters: CLKFREQ/BAUD set the clocks per bit (DIV, integer, >=4),
// DATA_BITS 5..8 (sent LSB first), PARITY 0=none/1=odd/2=even,
// STOP_BITS 1..2, FIFO_DEPTH a power of two, >=2.
//
// Ports:
//   clk, resetq        clock (posedge) and asynchronous active-low reset
//   rx / tx            serial input (asynchronous) and serial output (idle high)
//   wr, tx_data, busy  TX strobe, accepted only while busy=0
//   rd, valid          RX pop strobe and FIFO-not-empty
//   rx_data, rx_ferr,  head-of-FIFO data, stop-bit error and parity error
//   rx_perr
//   overrun,           sticky "frame dropped on a full FIFO" flag and its clear
//   clr_overrun
module uart_param #(
  parameter int unsigned CLKFREQ    = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 busy,
  input  logic                 rd,
  output logic                 valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ferr,
  output logic                 rx_perr,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int unsigned DIV = CLKFREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EW  = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_BIT   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // Bit counter runs DIV-1..0 in every non-idle state; state advances on 0.
  // tx_bit_q indexes data bits, then is reused to count stop bits.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q == TX_IDLE) begin
      if (wr) begin
        tx_state_d = TX_START;
        tx_cnt_d   = CNT_BIT;
        tx_bit_d   = '0;
        tx_shift_d = tx_data;
        tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else begin
      tx_cnt_d = CNT_BIT;
      case (tx_state_q)
        TX_START: tx_state_d = TX_DATA;
        TX_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
        TX_PARITY: tx_state_d = TX_STOP;
        TX_STOP: begin
          if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
          else                       tx_bit_d   = tx_bit_q + 1'b1;
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (tx_state_q != TX_IDLE);
    case (tx_state_q)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shift_q[0];
      TX_PARITY: tx = tx_par_q;
      default:   tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 rx_push;
  logic [EW-1:0]        rx_word;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  // Start detection needs a real 1->0 on the synchronised line, so a held-low
  // break yields one frame and nothing more until the line goes high again.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    if (rx_state_q == RX_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = CNT_HALF;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = CNT_BIT;
      case (rx_state_q)
        RX_START: begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
        RX_DATA: begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_DATA) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          else                       rx_bit_d   = rx_bit_q + 1'b1;
        end
        RX_PARITY: begin
          rx_pbit_d  = rx_s2_q;
          rx_state_d = RX_STOP;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    logic par_exp;
    par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
    rx_push = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
    rx_word = {(PARITY != 0) && (rx_pbit_q != par_exp), ~rx_s2_q, rx_shift_q};
  end

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          full, pop, do_push, drop;
  logic [EW-1:0] head;

  always_comb begin
    valid   = (count_q != '0);
    full    = (count_q == FULL_CNT);
    pop     = rd && valid;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    do_push = rx_push && (!full || pop);
    drop    = rx_push && full && !pop;

    wptr_d    = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    overrun_d = drop || (overrun_q && !clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= rx_word;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    head                         = valid ? mem_q[rptr_q] : '0;
    {rx_perr, rx_ferr, rx_data}  = head;
    overrun                      = overrun_q;
  end

endmodule

// File: tb/tb_uart_param.sv
`timescale 1ns/1ps
module tb_uart_param;
  localparam int unsigned CLKF = 1000000;
  localparam int unsigned BRATE = 100000;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic resetq;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       bit_q[$];
  logic [9:0] rx_q[$];

  // A: 8N1, rx driven by the bench
  logic a_rx, a_tx, a_wr, a_busy, a_rd, a_valid, a_ferr, a_perr, a_ovr, a_clr;
  logic [7:0] a_txd, a_rxd;
  // B: 7E2
  logic b_rx, b_tx, b_wr, b_busy, b_rd, b_valid, b_ferr, b_perr, b_ovr, b_clr;
  logic [6:0] b_txd, b_rxd;
  // C: 8O1 loopback
  logic c_tx, c_wr, c_busy, c_rd, c_valid, c_ferr, c_perr, c_ovr, c_clr;
  logic [7:0] c_txd, c_rxd;

  uart_param #(.CLKFREQ(CLKF), .BAUD(BRATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .resetq(resetq), .rx(a_rx), .tx(a_tx), .wr(a_wr), .tx_data(a_txd), .busy(a_busy),
    .rd(a_rd), .valid(a_valid), .rx_data(a_rxd), .rx_ferr(a_ferr), .rx_perr(a_perr),
    .overrun(a_ovr), .clr_overrun(a_clr));

  uart_param #(.CLKFREQ(CLKF), .BAUD(BRATE), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .resetq(resetq), .rx(b_rx), .tx(b_tx), .wr(b_wr), .tx_data(b_txd), .busy(b_busy),
    .rd(b_rd), .valid(b_valid), .rx_data(b_rxd), .rx_ferr(b_ferr), .rx_perr(b_perr),
    .overrun(b_ovr), .clr_overrun(b_clr));

  uart_param #(.CLKFREQ(CLKF), .BAUD(BRATE), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .resetq(resetq), .rx(c_tx), .tx(c_tx), .wr(c_wr), .tx_data(c_txd), .busy(c_busy),
    .rd(c_rd), .valid(c_valid), .rx_data(c_rxd), .rx_ferr(c_ferr), .rx_perr(c_perr),
    .overrun(c_ovr), .clr_overrun(c_clr));

  function automatic logic sel_tx(input int inst);
    case (inst)
      0: return a_tx;
      1: return b_tx;
      default: return c_tx;
    endcase
  endfunction

  function automatic logic sel_busy(input int inst);
    case (inst)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic sel_valid(input int inst);
    case (inst)
      0: return a_valid;
      1: return b_valid;
      default: return c_valid;
    endcase
  endfunction

  function automatic logic [9:0] sel_head(input int inst);
    case (inst)
      0: return {a_perr, a_ferr, a_rxd};
      1: return {b_perr, b_ferr, 1'b0, b_rxd};
      default: return {c_perr, c_ferr, c_rxd};
    endcase
  endfunction

  function automatic logic sel_ovr(input int inst);
    case (inst)
      0: return a_ovr;
      1: return b_ovr;
      default: return c_ovr;
    endcase
  endfunction

  task automatic set_wr(input int inst, input logic v, input logic [7:0] d);
    case (inst)
      0: begin a_wr = v; if (v) a_txd = d; end
      1: begin b_wr = v; if (v) b_txd = d[6:0]; end
      default: begin c_wr = v; if (v) c_txd = d; end
    endcase
  endtask

  task automatic set_rd(input int inst, input logic v);
    case (inst)
      0: a_rd = v;
      1: b_rd = v;
      default: c_rd = v;
    endcase
  endtask

  // All tasks start and end at a falling clock edge.
  task automatic start_tx(input int inst, input logic [7:0] d);
    set_wr(inst, 1'b1, d);
    @(negedge clk);
    set_wr(inst, 1'b0, d);
  endtask

  task automatic push_frame_bits(input logic [7:0] d, input int nbits, input int par, input int stops);
    logic x;
    x = 1'b0;
    bit_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bit_q.push_back(d[i]);
      x = x ^ d[i];
    end
    if (par == 1) bit_q.push_back(~x);
    else if (par == 2) bit_q.push_back(x);
    for (int i = 0; i < stops; i++) bit_q.push_back(1'b1);
  endtask

  task automatic run_tx_check(input int inst, input string name, input int poke);
    int   cyc;
    int   idx;
    logic expb, bad, got_tx, got_busy;
    cyc = 0;
    idx = 0;
    while (bit_q.size() > 0) begin
      expb = bit_q.pop_front();
      bad = 1'b0;
      got_tx = expb;
      got_busy = 1'b1;
      for (int j = 0; j < DIV; j++) begin
        if (sel_tx(inst) !== expb || sel_busy(inst) !== 1'b1) begin
          bad = 1'b1;
          got_tx = sel_tx(inst);
          got_busy = sel_busy(inst);
        end
        if (cyc == poke) set_wr(inst, 1'b1, 8'h7F);
        else if (cyc == poke + 1) set_wr(inst, 1'b0, 8'h00);
        cyc++;
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b busy=%b, required tx=%b busy=1", name, idx, got_tx, got_busy, expb);
      end
      idx++;
    end
    checks++;
    if (sel_busy(inst) !== 1'b0 || sel_tx(inst) !== 1'b1) begin
      errors++;
      $display("FAIL %s end: busy=%b tx=%b, required busy=0 tx=1", name, sel_busy(inst), sel_tx(inst));
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_lvl);
    a_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    a_rx = stop_lvl;
    repeat (DIV) @(negedge clk);
    a_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic pop_check(input int inst, input string name);
    logic [9:0] exp, got;
    int n;
    n = 0;
    while (sel_valid(inst) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
    got = sel_head(inst);
    checks++;
    if (sel_valid(inst) !== 1'b1 || got !== exp) begin
      errors++;
      $display("FAIL %s: valid=%b {perr,ferr,data}=%h, required valid=1 %h", name, sel_valid(inst), got, exp);
    end
    set_rd(inst, 1'b1);
    @(negedge clk);
    set_rd(inst, 1'b0);
  endtask

  task automatic check_idle_status(input int inst, input string name);
    logic [13:0] got;
    got = {sel_tx(inst), sel_busy(inst), sel_valid(inst), sel_ovr(inst), sel_head(inst)};
    checks++;
    if (got !== 14'b1000_0000000000) begin
      errors++;
      $display("FAIL %s: {tx,busy,valid,ovr,head}=%b, required %b", name, got, 14'b1000_0000000000);
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_status(0, "reset_a");
    check_idle_status(1, "reset_b");
    check_idle_status(2, "reset_c");
    resetq = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_8n1();
    push_frame_bits(8'hA5, 8, 0, 1);
    start_tx(0, 8'hA5);
    run_tx_check(0, "tx8n1_a5", -1);
  endtask

  task automatic test_tx_7e2();
    logic bad;
    push_frame_bits(8'h41, 7, 2, 2);
    start_tx(1, 8'h41);
    run_tx_check(1, "tx7e2_41", 30);
    bad = 1'b0;
    repeat (20) begin
      if (b_busy !== 1'b0 || b_tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL tx7e2_ignored_wr: busy/tx moved after frame, required busy=0 tx=1");
    end
  endtask

  task automatic test_loopback();
    push_frame_bits(8'h00, 8, 1, 1);
    rx_q.push_back({2'b00, 8'h00});
    start_tx(2, 8'h00);
    run_tx_check(2, "lb_tx_00", -1);
    push_frame_bits(8'hFF, 8, 1, 1);
    rx_q.push_back({2'b00, 8'hFF});
    start_tx(2, 8'hFF);
    run_tx_check(2, "lb_tx_ff", -1);
    pop_check(2, "lb_rx_00");
    pop_check(2, "lb_rx_ff");
    checks++;
    if (c_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_empty: valid=%b, required 0", c_valid);
    end
  endtask

  task automatic test_ferr_glitch();
    rx_q.push_back({2'b01, 8'h3C});
    drive_frame(8'h3C, 1'b0);
    a_rx = 1'b0;
    repeat (3) @(negedge clk);
    a_rx = 1'b1;
    repeat (30) @(negedge clk);
    pop_check(0, "ferr_frame");
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_push: valid=%b, required 0", a_valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_q.push_back({2'b00, vals[i]});
      drive_frame(vals[i], 1'b1);
    end
    checks++;
    if (a_valid !== 1'b1 || a_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: valid=%b overrun=%b, required 1 1", a_valid, a_ovr);
    end
    for (int i = 0; i < 4; i++) pop_check(0, "ovr_pop");
    checks++;
    if (a_valid !== 1'b0 || a_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: valid=%b overrun=%b, required 0 1", a_valid, a_ovr);
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    checks++;
    if (a_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: overrun=%b, required 0", a_ovr);
    end
  endtask

  task automatic test_back_to_back();
    push_frame_bits(8'h81, 8, 0, 1);
    start_tx(0, 8'h81);
    run_tx_check(0, "b2b_first", -1);
    push_frame_bits(8'h7E, 8, 0, 1);
    start_tx(0, 8'h7E);
    run_tx_check(0, "b2b_second", -1);
  endtask

  task automatic test_reset_midframe();
    drive_frame(8'hA7, 1'b1);
    checks++;
    if (a_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_prefill: valid=%b, required 1", a_valid);
    end
    start_tx(0, 8'h5A);
    a_rx = 1'b0;
    repeat (25) @(negedge clk);
    resetq = 1'b0;
    #1;
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b valid=%b, required 1 0 0", a_tx, a_busy, a_valid);
    end
    a_rx = 1'b1;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: valid=%b busy=%b, required 0 0", a_valid, a_busy);
    end
    push_frame_bits(8'hC3, 8, 0, 1);
    start_tx(0, 8'hC3);
    run_tx_check(0, "mid_tx_c3", -1);
    rx_q.push_back({2'b00, 8'h96});
    drive_frame(8'h96, 1'b1);
    pop_check(0, "mid_rx_96");
  endtask

  initial begin
    resetq = 1'b0;
    a_rx = 1'b1; a_wr = 1'b0; a_txd = '0; a_rd = 1'b0; a_clr = 1'b0;
    b_rx = 1'b1; b_wr = 1'b0; b_txd = '0; b_rd = 1'b0; b_clr = 1'b0;
    c_wr = 1'b0; c_txd = '0; c_rd = 1'b0; c_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_8n1();
    test_tx_7e2();
    test_loopback();
    test_ferr_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
